xy_issue_scheduler: RTL and testbench
=====================================

// Module: xy_issue_scheduler
// PURPOSE
//  Issue-stage scheduler for the X ALU (1-cycle) and the 4-stage Y multiplier, which share one writeback port.
//  Holds each decoded op until RAW, WAW and writeback-port hazards clear, then pulses the valid for X or Y.
//  Tracks in-flight results in a writeback reservation table. Tells writeback which unit owns the port each cycle.
// PARAMETERS
//  Y_LAT    4   Y issue-to-writeback latency in cycles (>=2)
//  X_LAT    1   X issue-to-writeback latency in cycles (< Y_LAT)
//  CNT_W    16  width of the saturating stall counters
// PORTS
//  clock              in   1      single clock, rising edge
//  reset              in   1      synchronous, active-high
//  id_is_valid        in   1      decoded op present
//  id_is_functionalunit in 2      2'd3 = Y multiply; 0..2 = X unit
//  id_is_rsa          in   5      source A register
//  id_is_rsa_used     in   1      source A is read
//  id_is_rsb          in   5      source B register
//  id_is_rsb_used     in   1      source B is read
//  id_is_regdest      in   5      destination register
//  id_is_writereg     in   1      op writes regdest (Y ops always 1)
//  is_id_ready        out  1      op accepted this cycle
//  is_x_valid         out  1      issue to X this cycle
//  is_y_valid         out  1      issue to Y this cycle
//  wb_sel             out  2      0 none, 1 X, 2 Y owns writeback this cycle
//  wb_regdest         out  5      destination expected at writeback this cycle
//  inflight_count     out  3      valid reservation slots
//  stall_data_cnt     out  CNT_W  cycles stalled on RAW/WAW
//  stall_port_cnt     out  CNT_W  cycles stalled on writeback-port conflict only
// BEHAVIOUR
//  - Reservation table: slots 1..Y_LAT, each {valid, unit, dest, writes}.
//  - Each clock every slot moves i -> i-1. Slot 1 is the cycle of writeback and is dropped on the next clock.
//  - An op accepted with latency L is written into slot L at that same clock edge.
//  - Only X ops with id_is_writereg=0 reserve nothing.
//  - L = Y_LAT if functionalunit == 3, else X_LAT.
//  - Hazard terms, computed combinationally on the current table (no forwarding):
//     raw : (rsa_used & rsa matches dest of any valid slot with writes=1) or the same for rsb.
//     waw : writereg & regdest matches dest of any valid slot with writes=1.
//     port: L < Y_LAT & slot[L+1].valid. Y never port-stalls, because an older op never sits in slot Y_LAT+1.
//     Register 0 never matches in raw or waw.
//  - Accept condition: id_is_valid & ~raw & ~waw & ~port.
//  - is_id_ready = accept condition; is_x_valid = accept & unit != 3; is_y_valid = accept & unit == 3. All are pure combinational, zero latency.
//  - An op that is not accepted must be held stable upstream. The scheduler keeps no queue.
//  - wb_sel and wb_regdest come from slot 1. A Y entry reports 2 even if the multiplier suppresses the write on overflow.
//  - inflight_count = popcount of the slot valid bits (0..Y_LAT).
//  - Counters saturate at all-ones:
//     stall_data_cnt increments when id_is_valid & (raw|waw).
//     stall_port_cnt increments when id_is_valid & port & ~raw & ~waw.
//  - Reset (synchronous, any time, including mid-flight):
//     all slots go invalid and both counters clear.
//     Next cycle: wb_sel=0, wb_regdest=0, inflight_count=0, is_id_ready=id_is_valid.
//     In-flight multiplier results are orphaned; the pipeline is reset on the same edge.
//  - Simultaneous events: slot shift and new insert happen on the same edge. Slot 1 retiring frees its dest for a RAW check in the following cycle, not the current one.
// TESTING
//  T1 Reset held 2 cycles, no ops:
//     -> wb_sel=0, inflight_count=0, counters 0.
//     Then id_is_valid=1, X op -> is_id_ready=1, is_x_valid=1 same cycle.
//  T2 RAW. Y op rd=r5 accepted c0; X op rsa=r5 presented c1:
//     -> is_id_ready=0 c1..c4, wb_sel=2/wb_regdest=5 at c4.
//     -> X issues c5; stall_data_cnt=4.
//  T3 Port conflict. Y op rd=r3 at c0; X ops rd=r7,r8,r9 presented from c1:
//     -> r7 issues c1, r8 issues c2.
//     -> r9 presented c3 stalls (slot2 valid), issues c4; stall_port_cnt=1.
//     -> wb_sel sequence c2..c5 = 1,1,2,1.
//  T4 WAW. Y rd=r4 at c0, X rd=r4 presented c1:
//     -> stalled c1..c4, issues c5, wb_sel=1 at c6.
//  T5 Back-to-back Y. Four independent Y ops c0..c3:
//     -> all accepted, inflight_count=4 at c4 and wb_sel=2 c4..c7.
//  T6 Reset mid-flight. Y op at c0, reset asserted c2:
//     -> c3 has inflight_count=0, wb_sel=0.
//     -> An X op reading the old dest issues at c3.

Source files
------------

// File: rtl/xy_issue_scheduler.sv
// xy_issue_scheduler
// Issue stage for the 1-cycle X ALU and the multi-cycle Y multiplier, which
// share one writeback port. A writeback reservation table (slots 1..Y_LAT)
// tracks in-flight results. A decoded op is accepted only when its RAW, WAW
// and writeback-port hazards are clear. Issue handshakes are combinational,
// so an op that is not accepted must be held stable upstream.
module xy_issue_scheduler #(
  parameter int Y_LAT = 4,
  parameter int X_LAT = 1,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_is_valid,
  input  logic [1:0]       id_is_functionalunit,
  input  logic [4:0]       id_is_rsa,
  input  logic             id_is_rsa_used,
  input  logic [4:0]       id_is_rsb,
  input  logic             id_is_rsb_used,
  input  logic [4:0]       id_is_regdest,
  input  logic             id_is_writereg,
  output logic             is_id_ready,
  output logic             is_x_valid,
  output logic             is_y_valid,
  output logic [1:0]       wb_sel,
  output logic [4:0]       wb_regdest,
  output logic [2:0]       inflight_count,
  output logic [CNT_W-1:0] stall_data_cnt,
  output logic [CNT_W-1:0] stall_port_cnt
);

  // Reservation table; slot 1 is the writeback cycle.
  logic [Y_LAT:1] slot_valid_q, slot_valid_d;
  logic [Y_LAT:1] slot_y_q,     slot_y_d;
  logic [Y_LAT:1] slot_writes_q, slot_writes_d;
  logic [4:0]     slot_dest_q [1:Y_LAT];
  logic [4:0]     slot_dest_d [1:Y_LAT];

  // Table after the per-clock shift, before any insert.
  logic [Y_LAT:1] shift_valid_s;
  logic [Y_LAT:1] shift_y_s;
  logic [Y_LAT:1] shift_writes_s;
  logic [4:0]     shift_dest_s [1:Y_LAT];

  logic [CNT_W-1:0] stall_data_cnt_q, stall_data_cnt_d;
  logic [CNT_W-1:0] stall_port_cnt_q, stall_port_cnt_d;

  logic is_y_s;
  logic reserve_s;
  logic raw_s;
  logic waw_s;
  logic port_s;
  logic accept_s;
  int   lat_s;

  assign is_y_s    = (id_is_functionalunit == 2'd3);
  assign reserve_s = is_y_s | id_is_writereg;
  assign lat_s     = is_y_s ? Y_LAT : X_LAT;

  // Hazard detection against the current table (no forwarding, r0 never matches).
  always_comb begin
    raw_s  = 1'b0;
    waw_s  = 1'b0;
    port_s = 1'b0;
    for (int i = 1; i <= Y_LAT; i++) begin
      if (slot_valid_q[i] && slot_writes_q[i]) begin
        if (id_is_rsa_used && (id_is_rsa != 5'd0) && (id_is_rsa == slot_dest_q[i])) begin
          raw_s = 1'b1;
        end else begin
          raw_s = raw_s;
        end
        if (id_is_rsb_used && (id_is_rsb != 5'd0) && (id_is_rsb == slot_dest_q[i])) begin
          raw_s = 1'b1;
        end else begin
          raw_s = raw_s;
        end
        if (id_is_writereg && (id_is_regdest != 5'd0) && (id_is_regdest == slot_dest_q[i])) begin
          waw_s = 1'b1;
        end else begin
          waw_s = waw_s;
        end
      end else begin
        raw_s = raw_s;
      end
    end
    // Y lands in the top slot, which nothing older can occupy, so only X port-stalls.
    if (!is_y_s) begin
      port_s = slot_valid_q[X_LAT+1];
    end else begin
      port_s = 1'b0;
    end
  end

  assign accept_s    = id_is_valid & ~raw_s & ~waw_s & ~port_s;
  assign is_id_ready = accept_s;
  assign is_x_valid  = accept_s & ~is_y_s;
  assign is_y_valid  = accept_s & is_y_s;

  // Shift every slot down by one; the top slot empties.
  always_comb begin
    for (int i = 1; i < Y_LAT; i++) begin
      shift_valid_s[i]  = slot_valid_q[i+1];
      shift_y_s[i]      = slot_y_q[i+1];
      shift_writes_s[i] = slot_writes_q[i+1];
      shift_dest_s[i]   = slot_dest_q[i+1];
    end
    shift_valid_s[Y_LAT]  = 1'b0;
    shift_y_s[Y_LAT]      = 1'b0;
    shift_writes_s[Y_LAT] = 1'b0;
    shift_dest_s[Y_LAT]   = 5'd0;
  end

  // Insert the accepted op into the slot matching its latency, on top of the shift.
  always_comb begin
    for (int i = 1; i <= Y_LAT; i++) begin
      if (accept_s && reserve_s && (i == lat_s)) begin
        slot_valid_d[i]  = 1'b1;
        slot_y_d[i]      = is_y_s;
        slot_writes_d[i] = 1'b1;
        slot_dest_d[i]   = id_is_regdest;
      end else begin
        slot_valid_d[i]  = shift_valid_s[i];
        slot_y_d[i]      = shift_y_s[i];
        slot_writes_d[i] = shift_writes_s[i];
        slot_dest_d[i]   = shift_dest_s[i];
      end
    end
  end

  // Saturating stall counters: data hazards, and port-only conflicts.
  always_comb begin
    stall_data_cnt_d = stall_data_cnt_q;
    stall_port_cnt_d = stall_port_cnt_q;
    if (id_is_valid && (raw_s || waw_s) && (stall_data_cnt_q != {CNT_W{1'b1}})) begin
      stall_data_cnt_d = stall_data_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_data_cnt_d = stall_data_cnt_q;
    end
    if (id_is_valid && port_s && !raw_s && !waw_s && (stall_port_cnt_q != {CNT_W{1'b1}})) begin
      stall_port_cnt_d = stall_port_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_port_cnt_d = stall_port_cnt_q;
    end
  end

  // State registers; reset orphans every in-flight result.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid_q     <= '0;
      slot_y_q         <= '0;
      slot_writes_q    <= '0;
      for (int i = 1; i <= Y_LAT; i++) begin
        slot_dest_q[i] <= 5'd0;
      end
      stall_data_cnt_q <= '0;
      stall_port_cnt_q <= '0;
    end else begin
      slot_valid_q     <= slot_valid_d;
      slot_y_q         <= slot_y_d;
      slot_writes_q    <= slot_writes_d;
      for (int i = 1; i <= Y_LAT; i++) begin
        slot_dest_q[i] <= slot_dest_d[i];
      end
      stall_data_cnt_q <= stall_data_cnt_d;
      stall_port_cnt_q <= stall_port_cnt_d;
    end
  end

  // Writeback owner and occupancy, derived from the registered table.
  always_comb begin
    if (slot_valid_q[1]) begin
      wb_sel     = slot_y_q[1] ? 2'd2 : 2'd1;
      wb_regdest = slot_dest_q[1];
    end else begin
      wb_sel     = 2'd0;
      wb_regdest = 5'd0;
    end
    inflight_count = 3'd0;
    for (int i = 1; i <= Y_LAT; i++) begin
      inflight_count = inflight_count + {2'b00, slot_valid_q[i]};
    end
  end

  assign stall_data_cnt = stall_data_cnt_q;
  assign stall_port_cnt = stall_port_cnt_q;

endmodule

// File: tb/tb_xy_issue_scheduler.sv
// Directed bench for xy_issue_scheduler with hand-computed expectations.
module tb_xy_issue_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_is_valid;
  logic [1:0]  id_is_functionalunit;
  logic [4:0]  id_is_rsa;
  logic        id_is_rsa_used;
  logic [4:0]  id_is_rsb;
  logic        id_is_rsb_used;
  logic [4:0]  id_is_regdest;
  logic        id_is_writereg;
  logic        is_id_ready;
  logic        is_x_valid;
  logic        is_y_valid;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_regdest;
  logic [2:0]  inflight_count;
  logic [15:0] stall_data_cnt;
  logic [15:0] stall_port_cnt;

  int vectors = 0;
  int miscompares = 0;

  xy_issue_scheduler #(.Y_LAT(4), .X_LAT(1), .CNT_W(16)) dut (
    .clock                (clock),
    .reset                (reset),
    .id_is_valid          (id_is_valid),
    .id_is_functionalunit (id_is_functionalunit),
    .id_is_rsa            (id_is_rsa),
    .id_is_rsa_used       (id_is_rsa_used),
    .id_is_rsb            (id_is_rsb),
    .id_is_rsb_used       (id_is_rsb_used),
    .id_is_regdest        (id_is_regdest),
    .id_is_writereg       (id_is_writereg),
    .is_id_ready          (is_id_ready),
    .is_x_valid           (is_x_valid),
    .is_y_valid           (is_y_valid),
    .wb_sel               (wb_sel),
    .wb_regdest           (wb_regdest),
    .inflight_count       (inflight_count),
    .stall_data_cnt       (stall_data_cnt),
    .stall_port_cnt       (stall_port_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; new inputs are applied 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #2;
  endtask

  task automatic idle();
    id_is_valid          = 1'b0;
    id_is_functionalunit = 2'd0;
    id_is_rsa            = 5'd0;
    id_is_rsa_used       = 1'b0;
    id_is_rsb            = 5'd0;
    id_is_rsb_used       = 1'b0;
    id_is_regdest        = 5'd0;
    id_is_writereg       = 1'b0;
  endtask

  task automatic op(input logic [1:0] fu, input logic [4:0] rsa, input logic rsa_u,
                    input logic [4:0] rsb, input logic rsb_u, input logic [4:0] rd,
                    input logic wr);
    id_is_valid          = 1'b1;
    id_is_functionalunit = fu;
    id_is_rsa            = rsa;
    id_is_rsa_used       = rsa_u;
    id_is_rsb            = rsb;
    id_is_rsb_used       = rsb_u;
    id_is_regdest        = rd;
    id_is_writereg       = wr;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 5; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    // T1: reset held two cycles
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("t1_wb_sel", wb_sel, 0);
    chk("t1_inflight", inflight_count, 0);
    chk("t1_stall_data", stall_data_cnt, 0);
    chk("t1_stall_port", stall_port_cnt, 0);
    op(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
    settle();
    chk("t1_ready", is_id_ready, 1);
    chk("t1_x_valid", is_x_valid, 1);
    chk("t1_y_valid", is_y_valid, 0);
    tick();
    idle();
    settle();
    chk("t1_wb_sel_x", wb_sel, 1);
    chk("t1_wb_rd", wb_regdest, 1);
    drain();

    // T2: RAW on a Y result
    op(2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    settle();
    chk("t2_y_valid", is_y_valid, 1);
    tick();
    op(2'd1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk("t2_stall_ready", is_id_ready, 0);
      if (c == 4) begin
        chk("t2_wb_sel", wb_sel, 2);
        chk("t2_wb_rd", wb_regdest, 5);
      end
      tick();
    end
    settle();
    chk("t2_issue_ready", is_id_ready, 1);
    chk("t2_issue_x", is_x_valid, 1);
    chk("t2_stall_data", stall_data_cnt, 4);
    tick();
    drain();

    // T3: writeback-port conflict
    op(2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
    tick();
    op(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    settle();
    chk("t3_r7_ready", is_id_ready, 1);
    tick();
    op(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
    settle();
    chk("t3_r8_ready", is_id_ready, 1);
    chk("t3_c2_wb_sel", wb_sel, 1);
    chk("t3_c2_wb_rd", wb_regdest, 7);
    tick();
    op(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    settle();
    chk("t3_r9_stall", is_id_ready, 0);
    chk("t3_c3_wb_sel", wb_sel, 1);
    chk("t3_c3_wb_rd", wb_regdest, 8);
    tick();
    settle();
    chk("t3_r9_ready", is_id_ready, 1);
    chk("t3_c4_wb_sel", wb_sel, 2);
    chk("t3_c4_wb_rd", wb_regdest, 3);
    tick();
    idle();
    settle();
    chk("t3_c5_wb_sel", wb_sel, 1);
    chk("t3_c5_wb_rd", wb_regdest, 9);
    chk("t3_stall_port", stall_port_cnt, 1);
    chk("t3_stall_data", stall_data_cnt, 4);
    drain();

    // T4: WAW on a Y destination
    op(2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    tick();
    op(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk("t4_stall_ready", is_id_ready, 0);
      tick();
    end
    settle();
    chk("t4_issue_ready", is_id_ready, 1);
    tick();
    idle();
    settle();
    chk("t4_wb_sel", wb_sel, 1);
    chk("t4_wb_rd", wb_regdest, 4);
    chk("t4_stall_data", stall_data_cnt, 8);
    chk("t4_stall_port", stall_port_cnt, 1);
    drain();

    // T5: four back-to-back Y ops
    for (int c = 0; c < 4; c++) begin
      op(2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'(10 + c), 1'b1);
      settle();
      chk("t5_y_ready", is_y_valid, 1);
      tick();
    end
    idle();
    settle();
    chk("t5_inflight", inflight_count, 4);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("t5_wb_sel", wb_sel, 2);
      chk("t5_wb_rd", wb_regdest, 10 + c);
      tick();
    end
    settle();
    chk("t5_wb_sel_end", wb_sel, 0);
    chk("t5_inflight_end", inflight_count, 0);
    drain();

    // T6: reset while a Y op is in flight
    op(2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1);
    tick();
    idle();
    tick();
    reset = 1'b1;
    settle();
    chk("t6_inflight_pre", inflight_count, 1);
    tick();
    reset = 1'b0;
    op(2'd0, 5'd20, 1'b1, 5'd0, 1'b0, 5'd21, 1'b1);
    settle();
    chk("t6_inflight", inflight_count, 0);
    chk("t6_wb_sel", wb_sel, 0);
    chk("t6_wb_rd", wb_regdest, 0);
    chk("t6_ready", is_id_ready, 1);
    chk("t6_x_valid", is_x_valid, 1);
    chk("t6_stall_data", stall_data_cnt, 0);
    tick();
    idle();
    settle();
    chk("t6_wb_sel_x", wb_sel, 1);
    chk("t6_wb_rd_x", wb_regdest, 21);
    drain();

    // Register 0 never creates a hazard
    op(2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    tick();
    op(2'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    settle();
    chk("r0_ready", is_id_ready, 1);
    chk("r0_inflight", inflight_count, 1);
    tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
